hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core, working alongside `forwardingunit`. Forwarding repairs data hazards without stalling. This block handles every hazard that forwarding cannot repair:
- load-use dependences, by inserting one bubble;
- instruction-cache and data-cache misses, by freezing the pipeline;
- taken branches and jumps, by flushing the wrong-path stages.

It drives the load and flush enables of the PC and all four pipeline registers. It also latches early cache responses so that a split I/D miss never loses data.

## Interface
Parameters:
- `CNT_W`, default 32, width of the performance counters (used only with `HAZARD_PERF_CNT_EN`).

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rs1_id_IfId`, `rs2_id_IfId`  in  `rv32i_reg`  source registers of the instruction in ID.
- `rd_id_IdEx`  in  `rv32i_reg`  destination register of the instruction in EX.
- `control_word_IdEx`  in  `rv32i_control_word`  uses the `read_mem` and `write_reg` fields.
- `control_word_ExMem`  in  `rv32i_control_word`  uses the `read_mem` and `write_mem` fields.
- `icache_read`  in  1  instruction fetch request is active.
- `icache_resp`  in  1  one-cycle instruction cache response.
- `dcache_resp`  in  1  one-cycle data cache response.
- `br_taken_Ex`  in  1  branch or jump in EX redirects the PC.
- `load_pc`, `load_IfId`, `load_IdEx`, `load_ExMem`, `load_MemWb`  out  1 each  register enables.
- `flush_IfId`, `flush_IdEx`  out  1 each  load a NOP (all-zero control word) in place of the incoming data.
- `stall_o`  out  1  high while the pipeline is frozen for memory.
- `lu_cnt`, `mem_cnt`, `flush_cnt`  out  `CNT_W` each  performance counters (present only with `HAZARD_PERF_CNT_EN`).

## Operation
Derived signals:
- `dreq` = `control_word_ExMem.read_mem | control_word_ExMem.write_mem`.
- `i_wait` = `icache_read & ~(icache_resp | i_done)`.
- `d_wait` = `dreq & ~(dcache_resp | d_done)`.
- `mem_busy` = `i_wait | d_wait`.
- `lu_haz` = `control_word_IdEx.read_mem & control_word_IdEx.write_reg & (rd_id_IdEx != 0) & (rd_id_IdEx == rs1_id_IfId | rd_id_IdEx == rs2_id_IfId)`.
  - The comparison is conservative: it ignores whether the instruction actually reads rs1/rs2.

State machine, state type `hazard::state_t`:
- RUN
  - `mem_busy` → all `load_*` = 0, `stall_o` = 1, next state MEM_WAIT.
  - Otherwise, `br_taken_Ex` → all loads = 1, `flush_IfId` = 1, `flush_IdEx` = 1.
  - Otherwise, `lu_haz` → `load_pc` = 0, `load_IfId` = 0; `load_IdEx` = 1 with `flush_IdEx` = 1; `load_ExMem` = `load_MemWb` = 1.
  - Otherwise → all loads = 1, no flushes.
- MEM_WAIT
  - All loads = 0 and `stall_o` = 1 while `mem_busy`.
  - `i_done` is set on `icache_resp` while `d_wait`; `d_done` is set on `dcache_resp` while `i_wait`.
  - When `mem_busy` drops, outputs follow the RUN priority (branch > load-use > normal) in that same cycle.
  - On the following edge: clear `i_done` and `d_done`, next state RUN.

Priority and boundary cases:
- Priority order: memory stall > branch flush > load-use.
  - A branch that coincides with a load-use hazard flushes only. The load-use instruction is on the wrong path.
- Simultaneous `icache_resp` and `dcache_resp` → release in that cycle; no done flag is set.
- A response that arrives while no request of that type is pending is ignored.
- The load-use bubble lasts exactly one cycle. The next cycle, EX holds the NOP, so `lu_haz` is 0.
- Reset asserted mid-stall: state returns to RUN immediately, done flags clear, counters zero.

## Timing
- Every output is combinational from the inputs, the state and the done flags. There is zero-cycle latency to the pipeline enables.
- Only `state`, `i_done`, `d_done` and the counters are registered.
- While `rst_n` = 0:
  - `state` = RUN, `i_done` = `d_done` = 0, counters = 0;
  - all `load_*` = 0, `flush_*` = 0, `stall_o` = 0.
- First edge after reset release: normal RUN behaviour.
- Cache request signals must stay asserted until the cycle in which the pipeline advances. The cache interface guarantees this.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `lu_cnt` increments on each load-use bubble cycle;
  - `mem_cnt` increments on each cycle with `stall_o` = 1;
  - `flush_cnt` increments on each branch flush;
  - all three saturate at all-ones.
- Macro undefined: the counter ports and logic are absent, and the remaining behaviour is identical.

## Structure
- In `rv32i_types`: new `hazard` package containing the enum `state_t` {RUN, MEM_WAIT}. This block reuses the existing `rv32i_reg` and `rv32i_control_word`.
- One sub-module, `hazard_sat_counter`, parameterised by `CNT_W`, with inputs `clk`, `rst_n`, `inc` and output `count`. It is instantiated three times, only under the macro.

## Test plan
- Load-use: IdEx `read_mem` = 1, `write_reg` = 1, `rd_id_IdEx` = 5, `rs2_id_IfId` = 5 → one cycle with `load_pc` = 0, `load_IfId` = 0, `flush_IdEx` = 1; the next cycle all loads = 1; `lu_cnt` = 1.
- `rd_id_IdEx` = 0 with a matching rs and a load in EX → no stall.
- Split miss: `icache_read` = 1 and `dreq` = 1; `icache_resp` arrives at cycle 2 and `dcache_resp` at cycle 5 →
  - `stall_o` = 1 through cycle 4;
  - `i_done` = 1 from cycle 3;
  - release at cycle 5, RUN at cycle 6;
  - `mem_cnt` = 5.
- `br_taken_Ex` = 1 together with `lu_haz` = 1 → `flush_IfId` = `flush_IdEx` = 1, `load_pc` = 1, `flush_cnt` = 1, `lu_cnt` unchanged.
- `rst_n` pulsed low during MEM_WAIT with `i_done` = 1 → immediately state = RUN, flags = 0, all outputs = 0 while low.
- Build without `HAZARD_PERF_CNT_EN` → identical enables across all of the above scenarios.

Source files
------------

// File: rtl/hazard.sv
// hazard: state type for the hazard controller
package hazard;
  typedef enum logic {RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I register index and the control-word fields the hazard logic reads
package rv32i_types;
  typedef logic [4:0] rv32i_reg;
  typedef struct packed {
    logic read_mem;
    logic write_mem;
    logic write_reg;
  } rv32i_control_word;
endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: saturating event counter
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use bubble, cache-miss freeze and branch flush control; HAZARD_PERF_CNT_EN adds counters
module hazard_unit
  import rv32i_types::*;
  import hazard::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  rv32i_reg          rs1_id_IfId,
  input  rv32i_reg          rs2_id_IfId,
  input  rv32i_reg          rd_id_IdEx,
  input  rv32i_control_word control_word_IdEx,
  input  rv32i_control_word control_word_ExMem,
  input  logic              icache_read,
  input  logic              icache_resp,
  input  logic              dcache_resp,
  input  logic              br_taken_Ex,
  output logic              load_pc,
  output logic              load_IfId,
  output logic              load_IdEx,
  output logic              load_ExMem,
  output logic              load_MemWb,
  output logic              flush_IfId,
  output logic              flush_IdEx,
  output logic              stall_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  lu_cnt,
  output logic [CNT_W-1:0]  mem_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);
  state_t state, state_nxt;
  logic i_done, d_done, dreq, i_wait, d_wait, mem_busy, lu_haz, unused_bits;
  assign dreq = control_word_ExMem.read_mem | control_word_ExMem.write_mem;
  assign i_wait = icache_read & ~(icache_resp | i_done);
  assign d_wait = dreq & ~(dcache_resp | d_done);
  assign mem_busy = i_wait | d_wait;
  assign lu_haz = control_word_IdEx.read_mem & control_word_IdEx.write_reg & (rd_id_IdEx != '0) &
                  (rd_id_IdEx == rs1_id_IfId | rd_id_IdEx == rs2_id_IfId);
  assign unused_bits = ^{control_word_IdEx.write_mem, control_word_ExMem.write_reg, 1'(CNT_W)};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      // an early response is held until the other side of a split miss completes
      i_done <= (i_done & ~(state == MEM_WAIT & ~mem_busy)) | (icache_read & icache_resp & d_wait);
      d_done <= (d_done & ~(state == MEM_WAIT & ~mem_busy)) | (dreq & dcache_resp & i_wait);
    end
  always_comb begin
    {load_pc, load_IfId, load_IdEx, load_ExMem, load_MemWb, flush_IfId, flush_IdEx, stall_o} = '0;
    state_nxt = mem_busy ? MEM_WAIT : RUN;
    if (!rst_n) state_nxt = RUN;
    else if (mem_busy) stall_o = 1'b1;
    else begin
      {load_pc, load_IfId} = {2{br_taken_Ex | ~lu_haz}};
      {load_IdEx, load_ExMem, load_MemWb} = '1;
      flush_IfId = br_taken_Ex;
      flush_IdEx = br_taken_Ex | lu_haz;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_IdEx & ~flush_IfId), .count(lu_cnt));
  hazard_sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall_o), .count(mem_cnt));
  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_IfId), .count(flush_cnt));
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit enables, stalls, flushes and counters
module tb_hazard_unit;
  import rv32i_types::*;
  import hazard::*;
  localparam logic [7:0] ZERO = 8'h00, NORM = 8'hF8, STALL = 8'h01, LU = 8'h3A, BR = 8'hFE;
  logic clk = 1'b0, rst_n = 1'b0;
  rv32i_reg rs1, rs2, rd;
  rv32i_control_word cw_idex, cw_exmem;
  logic icache_read, icache_resp, dcache_resp, br;
  logic load_pc, load_IfId, load_IdEx, load_ExMem, load_MemWb, flush_IfId, flush_IdEx, stall_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt, mem_cnt, flush_cnt;
`endif
  logic [7:0] exp_q[$];
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .rs1_id_IfId(rs1), .rs2_id_IfId(rs2), .rd_id_IdEx(rd),
    .control_word_IdEx(cw_idex), .control_word_ExMem(cw_exmem), .icache_read(icache_read),
    .icache_resp(icache_resp), .dcache_resp(dcache_resp), .br_taken_Ex(br),
    .load_pc(load_pc), .load_IfId(load_IfId), .load_IdEx(load_IdEx), .load_ExMem(load_ExMem),
    .load_MemWb(load_MemWb), .flush_IfId(flush_IfId), .flush_IdEx(flush_IdEx), .stall_o(stall_o)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_cnt(lu_cnt), .mem_cnt(mem_cnt), .flush_cnt(flush_cnt)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, {24'd0, load_pc, load_IfId, load_IdEx, load_ExMem, load_MemWb, flush_IfId, flush_IdEx, stall_o},
          {24'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {rs1, rs2, rd} = '0;
    cw_idex = '0;
    cw_exmem = '0;
    {icache_read, icache_resp, dcache_resp, br} = '0;
  endtask
  task automatic set_lu();
    cw_idex = '{read_mem: 1'b1, write_mem: 1'b0, write_reg: 1'b1};
    rd = 5'd5;
    rs1 = 5'd3;
    rs2 = 5'd5;
  endtask
`ifdef HAZARD_PERF_CNT_EN
  task automatic cnt(input string tag, input int l, input int m, input int f);
    check({tag, "_lu_cnt"}, lu_cnt, l);
    check({tag, "_mem_cnt"}, mem_cnt, m);
    check({tag, "_flush_cnt"}, flush_cnt, f);
  endtask
`endif
  initial begin
    idle();
    icache_read = 1'b1;
    @(posedge clk);
    #1;
    tick("reset_outs", ZERO);
    check("reset_state", 32'(dut.state), 32'(RUN));
`ifdef HAZARD_PERF_CNT_EN
    cnt("reset", 0, 0, 0);
`endif
    rst_n = 1'b1;
    idle();
    tick("idle", NORM);
    set_lu();
    tick("lu_bubble", LU);
    idle();
    tick("lu_after", NORM);
`ifdef HAZARD_PERF_CNT_EN
    cnt("lu", 1, 0, 0);
`endif
    set_lu();
    rd = 5'd0;
    rs1 = 5'd0;
    tick("lu_rd0", NORM);
    set_lu();
    cw_idex.write_reg = 1'b0;
    tick("lu_nowrite", NORM);
    idle();
    icache_read = 1'b1;
    cw_exmem.read_mem = 1'b1;
    tick("split_c0", STALL);
    tick("split_c1", STALL);
    icache_resp = 1'b1;
    tick("split_c2", STALL);
    icache_resp = 1'b0;
    check("split_i_done", 32'(dut.i_done), 1);
    tick("split_c3", STALL);
    tick("split_c4", STALL);
    dcache_resp = 1'b1;
    tick("split_c5", NORM);
    check("split_state", 32'(dut.state), 32'(RUN));
    idle();
    tick("split_c6", NORM);
`ifdef HAZARD_PERF_CNT_EN
    cnt("split", 1, 5, 0);
`endif
    icache_read = 1'b1;
    cw_exmem.write_mem = 1'b1;
    tick("simul_c0", STALL);
    {icache_resp, dcache_resp} = 2'b11;
    tick("simul_c1", NORM);
    check("simul_no_done", 32'({dut.i_done, dut.d_done}), 0);
    idle();
    cw_exmem.read_mem = 1'b1;
    icache_resp = 1'b1;
    tick("stray_iresp", STALL);
    icache_resp = 1'b0;
    dcache_resp = 1'b1;
    tick("stray_release", NORM);
    idle();
    icache_read = 1'b1;
    tick("stray_no_flag", STALL);
    icache_resp = 1'b1;
    tick("stray_irelease", NORM);
    idle();
    set_lu();
    br = 1'b1;
    tick("br_lu", BR);
`ifdef HAZARD_PERF_CNT_EN
    cnt("br_lu", 1, 8, 1);
`endif
    idle();
    br = 1'b1;
    tick("br_plain", BR);
    icache_read = 1'b1;
    tick("br_stalled", STALL);
    icache_resp = 1'b1;
    tick("br_release", BR);
`ifdef HAZARD_PERF_CNT_EN
    cnt("br", 1, 9, 3);
`endif
    idle();
    icache_read = 1'b1;
    cw_exmem.read_mem = 1'b1;
    tick("rst_mid_c0", STALL);
    icache_resp = 1'b1;
    tick("rst_mid_c1", STALL);
    icache_resp = 1'b0;
    tick("rst_mid_c2", STALL);
    check("rst_mid_i_done_pre", 32'(dut.i_done), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(dut.state), 32'(RUN));
    check("rst_mid_flags", 32'({dut.i_done, dut.d_done}), 0);
`ifdef HAZARD_PERF_CNT_EN
    cnt("rst_mid", 0, 0, 0);
`endif
    tick("rst_mid_outs", ZERO);
    rst_n = 1'b1;
    idle();
    tick("post_rst_idle", NORM);
    icache_read = 1'b1;
    tick("post_rst_stall", STALL);
    icache_resp = 1'b1;
    tick("post_rst_release", NORM);
`ifdef HAZARD_PERF_CNT_EN
    cnt("post_rst", 0, 1, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
